// File: rtl/stopwatch_btn_cond.sv
// Button conditioner for the stopwatch controller.
// Two raw, bouncing, asynchronous push-buttons (clear, start/pause) are
// synchronised, debounced by a small per-button FSM and turned into
// stretched command strobes R and P. Clear always wins over start/pause,
// so R and P are never high in the same cycle.

// Per-button synchroniser plus debounce FSM.
// o_accept pulses for one cycle when a press (0 -> 1) has been stable for
// DB_CYCLES consecutive synchronised samples; releases are debounced the
// same way but never produce an accept.
module stopwatch_btn_cond_db #(
  parameter int DB_CYCLES = 1000000,
  parameter int CW        = 20
) (
  input  logic c_clk,
  input  logic R_n,
  input  logic i_btn,
  output logic o_accept,
  output logic o_stable
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // stable 0
    S_ARM    = 2'd1,  // candidate press, counting
    S_HELD   = 2'd2,  // stable 1
    S_DISARM = 2'd3   // candidate release, counting
  } db_state_t;

  localparam logic [CW-1:0] DB_LIMIT = CW'(DB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  db_state_t     r_state;
  logic [CW-1:0] r_cnt;

  db_state_t     w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_accept;
  logic          w_btn_s;

  assign w_btn_s = r_sync2;

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM state and qualification counter registers.
  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state, counter and accept decode. The counter only counts while
  // a candidate level is being qualified; it leaves the counting state as
  // soon as it has reached DB_LIMIT, so it can never wrap.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_btn_s) begin
          w_state_next = S_ARM;
          w_cnt_next   = CW'(1);
        end
      end
      S_ARM: begin
        if (!w_btn_s) begin
          // Bounced back before qualifying: silently forget it.
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt >= DB_LIMIT) begin
          w_state_next = S_HELD;
          w_cnt_next   = '0;
          w_accept     = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!w_btn_s) begin
          w_state_next = S_DISARM;
          w_cnt_next   = CW'(1);
        end
      end
      S_DISARM: begin
        if (w_btn_s) begin
          // Release glitch: still held.
          w_state_next = S_HELD;
          w_cnt_next   = '0;
        end else if (r_cnt >= DB_LIMIT) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_accept = w_accept;
  assign o_stable = (r_state == S_HELD) || (r_state == S_DISARM);

endmodule

// Top level: two debounce channels, priority arbitration and stretchers.
module stopwatch_btn_cond #(
  parameter int DB_CYCLES    = 1000000,
  parameter int PULSE_CYCLES = 4,
  parameter int CW           = 20,
  parameter int PW           = 3
) (
  input  logic       c_clk,
  input  logic       R_n,
  input  logic       btn_r,
  input  logic       btn_p,
  output logic       R,
  output logic       P,
  output logic [1:0] btn_dbg
);

  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

  // Bit 1 = clear channel, bit 0 = start/pause channel.
  logic [1:0]    w_btn_raw;
  logic [1:0]    w_accept;
  logic [1:0]    w_stable;
  logic          w_p_start;
  logic [PW-1:0] r_r_cnt;
  logic [PW-1:0] r_p_cnt;

  assign w_btn_raw = {btn_r, btn_p};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      stopwatch_btn_cond_db #(
        .DB_CYCLES (DB_CYCLES),
        .CW        (CW)
      ) u_db (
        .c_clk    (c_clk),
        .R_n      (R_n),
        .i_btn    (w_btn_raw[gi]),
        .o_accept (w_accept[gi]),
        .o_stable (w_stable[gi])
      );
    end
  endgenerate

  // A P accept is dropped if R is accepted on the same edge or R is
  // already being stretched.
  assign w_p_start = w_accept[0] && !w_accept[1] && (r_r_cnt == '0);

  // Clear strobe stretcher; a new accept retriggers the full width.
  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      r_r_cnt <= '0;
    end else if (w_accept[1]) begin
      r_r_cnt <= PULSE_LOAD;
    end else if (r_r_cnt != '0) begin
      r_r_cnt <= r_r_cnt - 1'b1;
    end
  end

  // Start/pause strobe stretcher; cut short the moment a clear is accepted.
  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      r_p_cnt <= '0;
    end else if (w_accept[1]) begin
      r_p_cnt <= '0;
    end else if (w_p_start) begin
      r_p_cnt <= PULSE_LOAD;
    end else if (r_p_cnt != '0) begin
      r_p_cnt <= r_p_cnt - 1'b1;
    end
  end

  assign R       = (r_r_cnt != '0);
  assign P       = (r_p_cnt != '0);
  assign btn_dbg = w_stable;

endmodule

// File: tb/tb_stopwatch_btn_cond.sv
// Directed testbench for stopwatch_btn_cond with DB_CYCLES=8, PULSE_CYCLES=3.
// Inputs change 1 time unit after a rising edge; that next rising edge is
// "edge 0" for the hand-computed latencies (accept at edge 10).
module tb_stopwatch_btn_cond;

  logic       c_clk;
  logic       R_n;
  logic       btn_r;
  logic       btn_p;
  logic       R;
  logic       P;
  logic [1:0] btn_dbg;

  int n_total = 0;
  int n_pass  = 0;

  // Monitor counters, owned by the negedge monitor only.
  int   r_hi = 0;
  int   p_hi = 0;
  int   r_rises = 0;
  int   p_rises = 0;
  logic both_seen = 1'b0;
  logic r_prev = 1'b0;
  logic p_prev = 1'b0;

  // Snapshot bases taken by the stimulus.
  int b_r_hi, b_p_hi, b_r_rises, b_p_rises;

  stopwatch_btn_cond #(
    .DB_CYCLES    (8),
    .PULSE_CYCLES (3),
    .CW           (4),
    .PW           (2)
  ) dut (
    .c_clk   (c_clk),
    .R_n     (R_n),
    .btn_r   (btn_r),
    .btn_p   (btn_p),
    .R       (R),
    .P       (P),
    .btn_dbg (btn_dbg)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // Strobe monitor sampled on the falling edge.
  always @(negedge c_clk) begin
    if (R && P) both_seen <= 1'b1;
    if (R) r_hi <= r_hi + 1;
    if (P) p_hi <= p_hi + 1;
    if (R && !r_prev) r_rises <= r_rises + 1;
    if (P && !p_prev) p_rises <= p_rises + 1;
    r_prev <= R;
    p_prev <= P;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge c_clk);
    #1;
  endtask

  task automatic mark();
    b_r_hi    = r_hi;
    b_p_hi    = p_hi;
    b_r_rises = r_rises;
    b_p_rises = p_rises;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    R_n   = 1'b0;
    btn_r = 1'b0;
    btn_p = 1'b0;
    tick(2);
    check("reset_R", 32'(R), 32'd0);
    check("reset_P", 32'(P), 32'd0);
    check("reset_dbg", 32'(btn_dbg), 32'd0);
    R_n = 1'b1;
    tick(3);

    // Clean press on btn_p.
    mark();
    btn_p = 1'b1;
    tick(10);
    check("clean_P_edge9", 32'(P), 32'd0);
    tick(1);
    check("clean_P_edge10", 32'(P), 32'd1);
    check("clean_dbg_edge10", 32'(btn_dbg), 32'd1);
    tick(2);
    check("clean_P_edge12", 32'(P), 32'd1);
    tick(1);
    check("clean_P_edge13", 32'(P), 32'd0);
    tick(6);
    check("clean_P_width", 32'(p_hi - b_p_hi), 32'd3);
    check("clean_R_quiet", 32'(r_hi - b_r_hi), 32'd0);
    btn_p = 1'b0;
    tick(10);
    check("release_dbg_edge9", 32'(btn_dbg), 32'd1);
    tick(1);
    check("release_dbg_edge10", 32'(btn_dbg), 32'd0);
    tick(5);
    check("release_no_strobe", 32'(p_hi - b_p_hi), 32'd3);

    // Bounce: 1,0,1,0 with 3-cycle segments, then held.
    mark();
    btn_p = 1'b1; tick(3);
    btn_p = 1'b0; tick(3);
    btn_p = 1'b1; tick(3);
    btn_p = 1'b0; tick(3);
    btn_p = 1'b1;
    tick(10);
    check("bounce_P_edge9", 32'(P), 32'd0);
    tick(1);
    check("bounce_P_edge10", 32'(P), 32'd1);
    tick(9);
    check("bounce_one_strobe", 32'(p_rises - b_p_rises), 32'd1);
    check("bounce_P_width", 32'(p_hi - b_p_hi), 32'd3);
    btn_p = 1'b0;
    tick(12);

    // 7-cycle glitch: must be rejected.
    mark();
    btn_p = 1'b1; tick(7);
    btn_p = 1'b0; tick(3);
    check("glitch_dbg", 32'(btn_dbg), 32'd0);
    tick(9);
    check("glitch_no_strobe", 32'(p_hi - b_p_hi), 32'd0);

    // Simultaneous press: only R.
    mark();
    btn_r = 1'b1;
    btn_p = 1'b1;
    tick(11);
    check("simul_R_edge10", 32'(R), 32'd1);
    check("simul_P_edge10", 32'(P), 32'd0);
    check("simul_dbg", 32'(btn_dbg), 32'd3);
    tick(10);
    check("simul_R_width", 32'(r_hi - b_r_hi), 32'd3);
    check("simul_P_never", 32'(p_hi - b_p_hi), 32'd0);
    btn_r = 1'b0;
    btn_p = 1'b0;
    tick(12);
    check("simul_release_dbg", 32'(btn_dbg), 32'd0);
    check("simul_release_quiet", 32'((r_hi - b_r_hi) + (p_hi - b_p_hi)), 32'd3);

    // Priority override: P accepted, R accepted one edge later.
    mark();
    btn_p = 1'b1;
    tick(1);
    btn_r = 1'b1;
    tick(10);
    check("prio_P_edge10", 32'(P), 32'd1);
    check("prio_R_edge10", 32'(R), 32'd0);
    tick(1);
    check("prio_P_edge11", 32'(P), 32'd0);
    check("prio_R_edge11", 32'(R), 32'd1);
    tick(2);
    check("prio_R_edge13", 32'(R), 32'd1);
    tick(1);
    check("prio_R_edge14", 32'(R), 32'd0);
    tick(6);
    check("prio_P_width", 32'(p_hi - b_p_hi), 32'd1);
    check("prio_R_width", 32'(r_hi - b_r_hi), 32'd3);
    btn_p = 1'b0;
    btn_r = 1'b0;
    tick(12);

    // Reset during a P stretch, button kept held.
    btn_p = 1'b1;
    tick(11);
    check("rst1_P_before", 32'(P), 32'd1);
    R_n = 1'b0;
    #1;
    check("rst1_P_async", 32'(P), 32'd0);
    check("rst1_dbg_async", 32'(btn_dbg), 32'd0);
    tick(2);
    R_n = 1'b1;
    tick(10);
    check("rst1_P_edge9", 32'(P), 32'd0);
    tick(1);
    check("rst1_P_edge10", 32'(P), 32'd1);
    check("rst1_dbg_edge10", 32'(btn_dbg), 32'd1);
    btn_p = 1'b0;
    tick(14);

    // Reset during ARM at count 5, button kept held.
    btn_p = 1'b1;
    tick(7);
    R_n = 1'b0;
    #1;
    check("rst2_P_async", 32'(P), 32'd0);
    check("rst2_dbg_async", 32'(btn_dbg), 32'd0);
    tick(1);
    R_n = 1'b1;
    tick(10);
    check("rst2_P_edge9", 32'(P), 32'd0);
    tick(1);
    check("rst2_P_edge10", 32'(P), 32'd1);
    btn_p = 1'b0;
    tick(14);

    // Five press/release cycles on btn_r.
    mark();
    for (int i = 0; i < 5; i++) begin
      btn_r = 1'b1;
      tick(12);
      check("rep_rises", 32'(r_rises - b_r_rises), 32'(i + 1));
      btn_r = 1'b0;
      tick(12);
    end
    check("rep_R_width", 32'(r_hi - b_r_hi), 32'd15);
    check("rep_P_quiet", 32'(p_hi - b_p_hi), 32'd0);
    check("never_both_high", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
